// File: rtl/rgb_fade_pwm.sv
// Three-channel LED PWM fader: free-running PWM counter, per-frame shadowed duties,
// and a colour wheel that cross-fades red -> green -> blue -> red.
module rgb_fade_pwm #(
  parameter int PWM_BITS    = 8,
  parameter int STEP_FRAMES = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       en,
  output logic       led_r,
  output logic       led_g,
  output logic       led_b,
  output logic [1:0] phase,
  output logic       frame
);

  localparam logic [PWM_BITS-1:0] MAX = '1;
  localparam int FD_W = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
  localparam logic [FD_W-1:0] FD_LAST = FD_W'(STEP_FRAMES - 1);

  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic [FD_W-1:0]     frame_div_q, frame_div_d;
  logic [PWM_BITS-1:0] lvl_q, lvl_d;
  logic [1:0]          phase_q, phase_d;
  logic [PWM_BITS-1:0] duty_r_q, duty_g_q, duty_b_q;
  logic [PWM_BITS-1:0] dec_r, dec_g, dec_b;
  logic                led_r_q, led_g_q, led_b_q, frame_q;
  logic                wrap, lvl_step;

  assign wrap = (pwm_cnt_q == MAX);

  // Colour wheel: the outgoing colour ramps down while the incoming one ramps up.
  always_comb begin
    dec_r = '0;
    dec_g = '0;
    dec_b = '0;
    case (phase_q)
      2'd0: begin
        dec_r = MAX - lvl_q;
        dec_g = lvl_q;
      end
      2'd1: begin
        dec_g = MAX - lvl_q;
        dec_b = lvl_q;
      end
      2'd2: begin
        dec_b = MAX - lvl_q;
        dec_r = lvl_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    frame_div_d = frame_div_q;
    lvl_d       = lvl_q;
    phase_d     = phase_q;
    lvl_step    = 1'b0;
    if (wrap && en) begin
      if (frame_div_q == FD_LAST) begin
        frame_div_d = '0;
        lvl_step    = 1'b1;
      end else begin
        frame_div_d = frame_div_q + FD_W'(1);
      end
    end
    if (lvl_step) begin
      if (lvl_q == MAX) begin
        lvl_d   = '0;
        phase_d = (phase_q == 2'd2 || phase_q == 2'd3) ? 2'd0 : phase_q + 2'd1;
      end else begin
        lvl_d = lvl_q + PWM_BITS'(1);
        if (phase_q == 2'd3) phase_d = 2'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pwm_cnt_q   <= '0;
      frame_div_q <= '0;
      lvl_q       <= '0;
      phase_q     <= 2'd0;
      duty_r_q    <= '0;
      duty_g_q    <= '0;
      duty_b_q    <= '0;
      led_r_q     <= 1'b0;
      led_g_q     <= 1'b0;
      led_b_q     <= 1'b0;
      frame_q     <= 1'b0;
    end else begin
      pwm_cnt_q   <= pwm_cnt_q + PWM_BITS'(1);
      frame_div_q <= frame_div_d;
      lvl_q       <= lvl_d;
      phase_q     <= phase_d;
      // Duties only change at the frame boundary so no pulse is ever cut short.
      if (wrap) begin
        duty_r_q <= dec_r;
        duty_g_q <= dec_g;
        duty_b_q <= dec_b;
      end
      led_r_q <= (pwm_cnt_q < duty_r_q);
      led_g_q <= (pwm_cnt_q < duty_g_q);
      led_b_q <= (pwm_cnt_q < duty_b_q);
      frame_q <= wrap;
    end
  end

  assign led_r = led_r_q;
  assign led_g = led_g_q;
  assign led_b = led_b_q;
  assign phase = phase_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_rgb_fade_pwm.sv
// Bench for rgb_fade_pwm (PWM_BITS=4, STEP_FRAMES=2): cycle model built from step count
// arithmetic, directed reset/window checks and randomized enable traffic.
module tb_rgb_fade_pwm;

  localparam int NB   = 4;
  localparam int SF   = 2;
  localparam int MAXV = (1 << NB) - 1;
  localparam int PER  = 1 << NB;

  logic       clk;
  logic       resetn;
  logic       en;
  logic       led_r, led_g, led_b, frame;
  logic [1:0] phase;

  int checks   = 0;
  int failures = 0;

  // Model: s = total level steps taken since reset; lvl and phase follow from it.
  int m_cnt, m_fd, m_s, m_dr, m_dg, m_db;
  int m_lr, m_lg, m_lb, m_fr;
  int k;
  bit en_clean;
  int win_r, win_g, win_b;

  rgb_fade_pwm #(.PWM_BITS(NB), .STEP_FRAMES(SF)) dut (
    .clk   (clk),
    .resetn(resetn),
    .en    (en),
    .led_r (led_r),
    .led_g (led_g),
    .led_b (led_b),
    .phase (phase),
    .frame (frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  function automatic int duty_of(input int s, input int ch);
    int lv, ph;
    lv = s % PER;
    ph = (s / PER) % 3;
    case (ch)
      0: return (ph == 0) ? MAXV - lv : (ph == 2) ? lv : 0;
      1: return (ph == 0) ? lv : (ph == 1) ? MAXV - lv : 0;
      default: return (ph == 1) ? lv : (ph == 2) ? MAXV - lv : 0;
    endcase
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_fd = 0; m_s = 0;
    m_dr = 0; m_dg = 0; m_db = 0;
    m_lr = 0; m_lg = 0; m_lb = 0; m_fr = 0;
    k = 0; en_clean = 1'b1;
    win_r = 0; win_g = 0; win_b = 0;
  endtask

  // Called just after a negedge; advances one posedge and compares.
  task automatic tick(input bit e);
    bit w;
    en = e;
    if (!e) en_clean = 1'b0;
    w    = (m_cnt == MAXV);
    m_lr = (m_cnt < m_dr);
    m_lg = (m_cnt < m_dg);
    m_lb = (m_cnt < m_db);
    m_fr = w;
    if (w) begin
      m_dr = duty_of(m_s, 0);
      m_dg = duty_of(m_s, 1);
      m_db = duty_of(m_s, 2);
      if (e) begin
        m_fd++;
        if (m_fd == SF) begin
          m_fd = 0;
          m_s++;
        end
      end
    end
    m_cnt = (m_cnt + 1) % PER;
    k++;
    @(posedge clk);
    #1;
    chk("led_r", led_r, m_lr);
    chk("led_g", led_g, m_lg);
    chk("led_b", led_b, m_lb);
    chk("frame", frame, m_fr);
    chk("phase", phase, (m_s / PER) % 3);
    if (k >= 17 && k <= 32) begin
      win_r += led_r; win_g += led_g; win_b += led_b;
    end
    if (k == 32 && en_clean) begin
      chk("first_frame_r_high", win_r, 15);
      chk("first_frame_g_high", win_g, 0);
      chk("first_frame_b_high", win_b, 0);
      win_r = 0; win_g = 0; win_b = 0;
    end
    if (k >= 49 && k <= 64) begin
      win_r += led_r; win_g += led_g; win_b += led_b;
    end
    if (k == 64 && en_clean) begin
      chk("step1_frame_r_high", win_r, 14);
      chk("step1_frame_g_high", win_g, 1);
      chk("step1_frame_b_high", win_b, 0);
    end
    @(negedge clk);
  endtask

  task automatic hold_reset_and_release();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_led_r", led_r, 0);
    chk("rst_led_g", led_g, 0);
    chk("rst_led_b", led_b, 0);
    chk("rst_frame", frame, 0);
    chk("rst_phase", phase, 0);
    model_reset();
    resetn = 1'b1;
  endtask

  initial begin
    bit e;
    int guard;
    resetn = 1'b0;
    en     = 1'b1;
    model_reset();
    @(negedge clk);
    hold_reset_and_release();

    // Full colour cycle and a bit beyond with enable held high.
    for (int i = 0; i < 1700; i++) tick(1'b1);

    // Enable frozen for ten frames, then resumed.
    for (int i = 0; i < 10 * PER; i++) tick(1'b0);
    for (int i = 0; i < 4 * PER; i++) tick(1'b1);

    // Randomized enable, mostly per-frame with occasional mid-frame flips.
    e = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if (m_cnt == 0) e = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 31) == 0) e = !e;
      tick(e);
    end

    // Asynchronous reset while red is lit.
    guard = 0;
    while (m_lr == 0 && guard < 2000) begin
      tick(1'b1);
      guard++;
    end
    chk("async_wait_led_r_high", led_r, 1);
    #2;
    resetn = 1'b0;
    #1;
    chk("async_led_r", led_r, 0);
    chk("async_led_g", led_g, 0);
    chk("async_led_b", led_b, 0);
    chk("async_frame", frame, 0);
    @(negedge clk);
    hold_reset_and_release();
    for (int i = 0; i < 100; i++) tick(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rgb_fade_pwm.md
# rgb_fade_pwm

Three-channel LED PWM fader that drives the board's RGB/LED pins from the MachXO2 internal-oscillator clock domain. It replaces the raw free-running counter-bit LED drive with a glitch-free PWM engine and a colour-wheel state machine that cross-fades red→green→blue→red. One instance sits between the `OSCH`-derived clock and the top-level LED pins.

## Interface

Parameters:
- `PWM_BITS`, 8: PWM and level resolution N; MAX = 2^N−1; legal 2..16.
- `STEP_FRAMES`, 4: PWM frames per brightness step; legal ≥1.

Ports:
- `clk` input 1: sole clock (OSCH output, nominally 2.08 MHz); all state rises on posedge.
- `resetn` input 1: reset; one clock; reset is asynchronous and active-low.
- `en` input 1: fade enable; low freezes level/phase progression, PWM keeps running.
- `led_r` output 1: red PWM, registered.
- `led_g` output 1: green PWM, registered.
- `led_b` output 1: blue PWM, registered.
- `phase` output 2: current colour phase (0, 1, 2).
- `frame` output 1: registered one-cycle pulse, high while `pwm_cnt`==0 (first cycle of each frame).

## Operation

- `pwm_cnt` (N bits): increments every cycle unconditionally, wraps MAX→0. The "wrap edge" is the edge on which it goes MAX→0.
- `frame_div` (0..STEP_FRAMES−1): on each wrap edge with `en`=1, increments; at STEP_FRAMES−1 it returns to 0 and issues a level step. With STEP_FRAMES=1 every wrap edge steps.
- `lvl` (N bits): on level step, increments; at MAX it returns to 0 and `phase` advances 0→1→2→0. Phase value 3 is unreachable; if present, it goes to 0 on the next level step and all duties decode as 0.
- Duty decode from (`phase`, `lvl`):
  - phase 0: r=MAX−lvl, g=lvl, b=0.
  - phase 1: g=MAX−lvl, b=lvl, r=0.
  - phase 2: b=MAX−lvl, r=lvl, g=0.
- Shadow duties `duty_r/g/b`: loaded only on wrap edges, from the pre-edge `phase`/`lvl`, independent of `en`. No duty changes mid-frame; no runt pulses.
- Output compare: on every edge, `led_x` <= (`pwm_cnt` < `duty_x`), using pre-edge values. Duty 0 → constantly low; duty MAX → high MAX of 2^N cycles per frame.
- `en`=0: `frame_div`, `lvl` and `phase` hold. Shadow loads and PWM continue, so the output is a steady colour. Re-asserting `en` resumes from the held `frame_div`.

## Timing

- Reset (asynchronous, immediate, no clock needed): `pwm_cnt`=0, `frame_div`=0, `lvl`=0, `phase`=0, all duties 0, `led_r/g/b`=0, `frame`=0.
- Edge k = k-th posedge after `resetn` deasserts. `pwm_cnt` after edge k = k mod 2^N. The first wrap edge is 2^N.
- The first frame after reset is dark, because the shadow duties are still 0.
- Compare latency: one cycle from `pwm_cnt`/duty to the pin.
- Duty latency: a level step on wrap edge W becomes visible in the duties at wrap edge W+2^N, and on the pins one cycle later.
- `frame`: high after wrap edges only; first high after edge 2^N.
- Full colour cycle: 3 × 2^N × STEP_FRAMES × 2^N cycles. With defaults this is 786 432 cycles, ≈0.38 s at 2.08 MHz.
- `resetn` asserted mid-frame: pins drop low asynchronously. After release, the sequence restarts exactly as from power-on.

## Test plan

All scenarios use `PWM_BITS`=4, `STEP_FRAMES`=2 (MAX=15), `en`=1 unless noted.

- **Reset:** hold `resetn` low with `clk` running → all outputs 0. Release → `led_*` stay 0 for edges 1..16; `frame` first high after edge 16 and low after edge 17.
- **First duties:** after edge 16, duty_r=15 and duty_g=duty_b=0. Required response: `led_r` high after edges 17..31 (15 cycles), low after edge 32; `led_g`, `led_b` always 0.
- **Level step:** `lvl` becomes 1 at edge 32, loaded at edge 48. During the frame following edge 48: `led_r` high 14 cycles, `led_g` high 1 cycle, `led_b` 0.
- **Phase wrap:** `phase` becomes 1 at edge 16·2·16 = 512; becomes 2 at edge 1024; returns to 0 at edge 1536. Check `led_b`=0 throughout phase 0, and `led_r`=0 throughout phase 1 (after the one-frame duty latency).
- **Enable freeze:** drop `en` mid-phase for 10 frames → `lvl`, `phase`, `frame_div` constant, each frame's pin pattern identical, `frame` still pulses every 16 cycles. Raise `en` → progression resumes with no skipped or repeated level.
- **Async reset mid-frame:** assert `resetn` low between clock edges while `led_r`=1 → `led_r` goes 0 before the next edge. Release → same sequence as the reset scenario.
